// File: rtl/rv0_core_pkg.sv
// rv0_core_pkg: shared constants for the rv0 pipeline-stage buffers.
//   RV0_INSN_NOP : canonical NOP (addi x0, x0, 0), shown by empty stages.
//   SBUF_DEPTH   : entries held by a skid-buffer sink.
//   SBUF_CNT_W   : occupancy counter width (must hold 0..SBUF_DEPTH).
//   SBUF_PTR_W   : read/write pointer width.
package rv0_core_pkg;

    localparam logic [31:0] RV0_INSN_NOP = 32'h0000_0013;

    localparam int unsigned SBUF_DEPTH = 2;
    localparam int unsigned SBUF_CNT_W = $clog2(SBUF_DEPTH + 1);
    localparam int unsigned SBUF_PTR_W = (SBUF_DEPTH > 1) ? $clog2(SBUF_DEPTH) : 1;

    // Advance a ring pointer, wrapping after the last entry.
    function automatic logic [SBUF_PTR_W-1:0] sbuf_ptr_inc(input logic [SBUF_PTR_W-1:0] ptr);
        if (ptr == SBUF_PTR_W'(SBUF_DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/rv_sbuf_if.sv
// rv_sbuf_if: pipeline-stage transfer interface between two skid-buffered stages.
//   rdy                    : source has a valid entry on the payload lines.
//   ack                    : sink can accept an entry this cycle (transfer = rdy && ack).
//   addr, insn             : entry address and instruction word.
//   idata1/idata2          : integer operands (XLEN bits).
//   fdata1/fdata2          : float operands (FLEN bits).
// Modports: source drives rdy and payload; sink drives ack.
interface rv_sbuf_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned FLEN = 32
);
    logic            rdy;
    logic            ack;
    logic [XLEN-1:0] addr;
    logic [31:0]     insn;
    logic [XLEN-1:0] idata1;
    logic [XLEN-1:0] idata2;
    logic [FLEN-1:0] fdata1;
    logic [FLEN-1:0] fdata2;

    modport source (
        output rdy, addr, insn, idata1, idata2, fdata1, fdata2,
        input  ack
    );

    modport sink (
        input  rdy, addr, insn, idata1, idata2, fdata1, fdata2,
        output ack
    );
endinterface

// File: rtl/rv0_perf_cnt.sv
// rv0_perf_cnt: free-running event counter with enable; wraps from all-ones to zero.
//   clk_i : clock
//   rst_i : asynchronous active-high reset, clears the count
//   en_i  : count this cycle
//   cnt_o : current count
module rv0_perf_cnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rv0_sbuf_sink.sv
// rv0_sbuf_sink: consumer end of an rv_sbuf_if link; 2-entry elastic buffer.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   flush_i   : drop every buffered entry (wins over a same-cycle push/pop)
//   sbuf_if   : upstream link (sink modport); ack depends on the occupancy flop only
//   valid_o   : head entry valid toward the next stage
//   ready_i   : next stage takes the head entry
//   addr_o, insn_o, idata1_o, idata2_o, fdata1_o, fdata2_o : head entry fields
//                 (NOP / zero while empty)
// Optional build macro RV0_SBUF_SINK_PERF_EN adds:
//   stall_cnt_o  : cycles with upstream rdy held off by ack = 0
//   bubble_cnt_o : cycles with downstream ready but nothing valid
module rv0_sbuf_sink
    import rv0_core_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned FLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    rv_sbuf_if.sink         sbuf_if,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] addr_o,
    output logic [31:0]     insn_o,
    output logic [XLEN-1:0] idata1_o,
    output logic [XLEN-1:0] idata2_o,
    output logic [FLEN-1:0] fdata1_o,
    output logic [FLEN-1:0] fdata2_o
`ifdef RV0_SBUF_SINK_PERF_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     bubble_cnt_o
`endif
);

    localparam int unsigned PW = 32 + 3 * XLEN + 2 * FLEN;

    // Packed entry layout: {addr, insn, idata1, idata2, fdata1, fdata2}.
    localparam logic [PW-1:0] ENTRY_RST =
        {{XLEN{1'b0}}, RV0_INSN_NOP, {(2 * XLEN + 2 * FLEN){1'b0}}};

    logic [PW-1:0]         mem_q [SBUF_DEPTH];
    logic [SBUF_PTR_W-1:0] wptr_q;
    logic [SBUF_PTR_W-1:0] rptr_q;
    logic [SBUF_CNT_W-1:0] count_q;
    logic [SBUF_CNT_W-1:0] count_d;

    logic          ack;
    logic          push;
    logic          pop;
    logic [PW-1:0] wr_data;
    logic [PW-1:0] head;

    // ack comes straight from the occupancy flop, so upstream never sees a
    // combinational path from ready_i.
    assign ack         = (count_q != SBUF_CNT_W'(SBUF_DEPTH));
    assign sbuf_if.ack = ack;
    assign valid_o     = (count_q != '0);

    assign push = sbuf_if.rdy && ack;
    assign pop  = valid_o && ready_i;

    assign wr_data = {sbuf_if.addr, sbuf_if.insn, sbuf_if.idata1, sbuf_if.idata2,
                      sbuf_if.fdata1, sbuf_if.fdata2};

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            for (int unsigned i = 0; i < SBUF_DEPTH; i++) begin
                mem_q[i] <= ENTRY_RST;
            end
        end else if (flush_i) begin
            // Storage is left as is; only the bookkeeping is cleared.
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wptr_q] <= wr_data;
                wptr_q        <= sbuf_ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= sbuf_ptr_inc(rptr_q);
            end
        end
    end

    // Stale storage is never exposed: an empty buffer presents a NOP.
    always_comb begin
        head = ENTRY_RST;
        if (count_q != '0) begin
            head = mem_q[rptr_q];
        end
    end

    assign {addr_o, insn_o, idata1_o, idata2_o, fdata1_o, fdata2_o} = head;

`ifdef RV0_SBUF_SINK_PERF_EN
    logic stall_evt;
    logic bubble_evt;

    assign stall_evt  = sbuf_if.rdy && !ack;
    assign bubble_evt = ready_i && !valid_o;

    rv0_perf_cnt #(
        .Width (32)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_evt),
        .cnt_o (stall_cnt_o)
    );

    rv0_perf_cnt #(
        .Width (32)
    ) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (bubble_evt),
        .cnt_o (bubble_cnt_o)
    );
`endif

endmodule

// File: tb/tb_rv0_sbuf_sink.sv
// tb_rv0_sbuf_sink: directed scenarios for rv0_sbuf_sink with a queue scoreboard.
// Optional macro RV0_SBUF_SINK_PERF_EN enables the performance-counter scenario.
module tb_rv0_sbuf_sink;

    localparam int XL = 32;
    localparam int FL = 32;
    localparam int PW = 32 + 3 * XL + 2 * FL;
    localparam logic [PW-1:0] NOP_P = {32'h0, 32'h13, 128'h0};

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic ready_i;
    logic valid_o;
    logic [XL-1:0] addr_o;
    logic [31:0]   insn_o;
    logic [XL-1:0] idata1_o;
    logic [XL-1:0] idata2_o;
    logic [FL-1:0] fdata1_o;
    logic [FL-1:0] fdata2_o;
`ifdef RV0_SBUF_SINK_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    rv_sbuf_if #(.XLEN(XL), .FLEN(FL)) sbuf ();

    rv0_sbuf_sink #(
        .XLEN (XL),
        .FLEN (FL)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (flush),
        .sbuf_if  (sbuf),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .addr_o   (addr_o),
        .insn_o   (insn_o),
        .idata1_o (idata1_o),
        .idata2_o (idata2_o),
        .fdata1_o (fdata1_o),
        .fdata2_o (fdata2_o)
`ifdef RV0_SBUF_SINK_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int mcnt = 0;
    logic [PW-1:0] exp_q[$];
    logic [31:0]   log_q[$];
    logic [31:0]   exp_log[$];

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [31:0] a, input logic [31:0] i);
        logic [31:0] sw;
        sw = {i[15:0], i[31:16]};
        return {a, i, i ^ 32'h1111_0000, i + 32'h100, ~i, sw};
    endfunction

    task automatic src(input logic r, input logic [31:0] a, input logic [31:0] i);
        sbuf.rdy = r;
        {sbuf.addr, sbuf.insn, sbuf.idata1, sbuf.idata2, sbuf.fdata1, sbuf.fdata2} = mk(a, i);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_logs(input string nm);
        chk({nm, "_len"}, PW'(log_q.size()), PW'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++) begin
            chk({nm, "_order"}, PW'(log_q[i]), PW'(exp_log[i]));
        end
        log_q.delete();
    endtask

    // Reference occupancy model; expected payloads queued on acceptance.
    always @(posedge clk or posedge rst) begin
        logic m_push;
        logic m_pop;
        if (rst) begin
            mcnt = 0;
            exp_q.delete();
        end else if (flush) begin
            mcnt = 0;
            exp_q.delete();
        end else begin
            m_push = sbuf.rdy && (mcnt != 2);
            m_pop  = (mcnt != 0) && ready_i;
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) exp_q.push_back({sbuf.addr, sbuf.insn, sbuf.idata1, sbuf.idata2,
                                         sbuf.fdata1, sbuf.fdata2});
            mcnt = mcnt + int'(m_push) - int'(m_pop);
        end
    end

    // Monitor: compares DUT outputs with the model mid-cycle and logs pops.
    always @(negedge clk) begin
        logic [PW-1:0] dut_p;
        dut_p = {addr_o, insn_o, idata1_o, idata2_o, fdata1_o, fdata2_o};
        if (rst) begin
            chk("rst_valid", PW'(valid_o), PW'(0));
            chk("rst_ack", PW'(sbuf.ack), PW'(1));
            chk("rst_out", dut_p, NOP_P);
        end else begin
            chk("ack", PW'(sbuf.ack), PW'(mcnt != 2));
            chk("valid", PW'(valid_o), PW'(mcnt != 0));
            if (mcnt != 0 && exp_q.size() != 0) begin
                chk("head", dut_p, exp_q[0]);
                if (ready_i && !flush) log_q.push_back(insn_o);
            end else begin
                chk("idle_out", dut_p, NOP_P);
            end
        end
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ready_i = 1'b0;
        src(1'b0, 32'h0, 32'h0);
        repeat (2) step;
        chk("reset_valid", PW'(valid_o), PW'(0));
        chk("reset_ack", PW'(sbuf.ack), PW'(1));
        chk("reset_insn", PW'(insn_o), PW'(32'h13));
        rst = 1'b0;

        // Single transfer with one-cycle latency.
        step;
        ready_i = 1'b1;
        src(1'b1, 32'h100, 32'h0050_0093);
        step;
        src(1'b0, 32'h0, 32'h0);
        #1;
        chk("t1_valid", PW'(valid_o), PW'(1));
        chk("t1_insn", PW'(insn_o), PW'(32'h0050_0093));
        chk("t1_addr", PW'(addr_o), PW'(32'h100));
        step;
        chk("t1_valid_after", PW'(valid_o), PW'(0));
        chk("t1_insn_after", PW'(insn_o), PW'(32'h13));
        exp_log = {32'h0050_0093};
        check_logs("t1");

        // Fill to two entries, hold a third under backpressure, then drain.
        ready_i = 1'b0;
        src(1'b1, 32'h0, 32'h11);
        step;
        src(1'b1, 32'h0, 32'h22);
        step;
        src(1'b1, 32'h0, 32'h33);
        #1;
        chk("t2_ack_full", PW'(sbuf.ack), PW'(0));
        repeat (3) begin
            step;
            chk("t2_ack_held", PW'(sbuf.ack), PW'(0));
        end
        ready_i = 1'b1;
        step;
        step;
        src(1'b0, 32'h0, 32'h0);
        repeat (4) step;
        exp_log = {32'h11, 32'h22, 32'h33};
        check_logs("t2");

        // Streaming: push and pop every cycle.
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            src(1'b1, 32'h0, 32'(i));
            step;
            chk("t3_ack", PW'(sbuf.ack), PW'(1));
            chk("t3_valid", PW'(valid_o), PW'(1));
        end
        src(1'b0, 32'h0, 32'h0);
        repeat (3) step;
        exp_log = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        check_logs("t3");

        // Flush while full with a push offered.
        ready_i = 1'b0;
        src(1'b1, 32'h0, 32'h55);
        step;
        src(1'b1, 32'h0, 32'h66);
        step;
        flush = 1'b1;
        src(1'b1, 32'h0, 32'h77);
        step;
        flush = 1'b0;
        src(1'b0, 32'h0, 32'h0);
        #1;
        chk("t4_valid", PW'(valid_o), PW'(0));
        chk("t4_ack", PW'(sbuf.ack), PW'(1));
        chk("t4_insn", PW'(insn_o), PW'(32'h13));
        ready_i = 1'b1;
        src(1'b1, 32'h0, 32'h44);
        step;
        src(1'b0, 32'h0, 32'h0);
        repeat (3) step;
        exp_log = {32'h44};
        check_logs("t4");

        // Flush at one entry with simultaneous push and pop: both discarded.
        ready_i = 1'b0;
        src(1'b1, 32'h0, 32'h88);
        step;
        ready_i = 1'b1;
        flush = 1'b1;
        src(1'b1, 32'h0, 32'h99);
        step;
        flush = 1'b0;
        src(1'b0, 32'h0, 32'h0);
        #1;
        chk("t4b_valid", PW'(valid_o), PW'(0));
        repeat (2) step;
        exp_log.delete();
        check_logs("t4b");

        // Asynchronous reset between edges while full.
        ready_i = 1'b0;
        src(1'b1, 32'h0, 32'ha1);
        step;
        src(1'b1, 32'h0, 32'ha2);
        step;
        src(1'b0, 32'h0, 32'h0);
        chk("t5_ack_pre", PW'(sbuf.ack), PW'(0));
        #1;
        rst = 1'b1;
        #1;
        chk("t5_valid", PW'(valid_o), PW'(0));
        chk("t5_ack", PW'(sbuf.ack), PW'(1));
        chk("t5_insn", PW'(insn_o), PW'(32'h13));
        step;
        rst = 1'b0;
        ready_i = 1'b1;
        src(1'b1, 32'h0, 32'hb1);
        step;
        src(1'b0, 32'h0, 32'h0);
        repeat (3) step;
        exp_log = {32'hb1};
        check_logs("t5");

`ifdef RV0_SBUF_SINK_PERF_EN
        begin
            logic [31:0] s0;
            logic [31:0] b0;
            ready_i = 1'b0;
            src(1'b1, 32'h0, 32'hc1);
            step;
            src(1'b1, 32'h0, 32'hc2);
            step;
            s0 = stall_cnt_o;
            src(1'b1, 32'h0, 32'hc3);
            repeat (5) step;
            src(1'b0, 32'h0, 32'h0);
            chk("perf_stall", PW'(stall_cnt_o - s0), PW'(5));
            s0 = stall_cnt_o;
            b0 = bubble_cnt_o;
            flush = 1'b1;
            step;
            flush = 1'b0;
            chk("perf_stall_flush", PW'(stall_cnt_o), PW'(s0));
            chk("perf_bubble_flush", PW'(bubble_cnt_o), PW'(b0));
            ready_i = 1'b1;
            repeat (3) step;
            ready_i = 1'b0;
            chk("perf_bubble", PW'(bubble_cnt_o - b0), PW'(3));
            step;
            exp_log.delete();
            check_logs("perf");
        end
`endif

        step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv0_sbuf_sink.md
Name: rv0_sbuf_sink

Overview:
- Receiving end of the rv_sbuf_if pipeline-stage interface: the consumer side of a skid buffer.
- Holds a 2-entry elastic buffer. Ack toward the upstream stage comes only from flops and never combinationally from downstream ready.
- Presents the head entry to the next stage (decode/execute/LSU) with a valid/ready handshake. Drops all buffered entries on pipeline flush.

Parameters:
- XLEN, 32, integer register / address width.
- FLEN, 32, float register data width.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- flush_i  input  1  pipeline flush; discards all buffered entries.
- sbuf_if  modport rv_sbuf_if.sink  -  upstream interface:
  - sink reads rdy, addr[XLEN], insn[32], idata1/idata2[XLEN], fdata1/fdata2[FLEN].
  - sink drives ack.
- valid_o  output  1  head entry valid toward downstream.
- ready_i  input  1  downstream accepts head entry.
- addr_o  output  XLEN  head entry address.
- insn_o  output  32  head entry instruction.
- idata1_o, idata2_o  output  XLEN  head integer operands.
- fdata1_o, fdata2_o  output  FLEN  head float operands.

Behaviour:
- Clock/reset: one clock, clk_i; reset rst_i is asynchronous, active-high.
- Storage: 2 entries of {addr, insn, idata1, idata2, fdata1, fdata2}. 1-bit write pointer wptr, 1-bit read pointer rptr, 2-bit count (0..2).
- Push: occurs when sbuf_if.rdy && sbuf_if.ack. Payload is written to entry[wptr], then wptr toggles.
- Pop: occurs when valid_o && ready_i. rptr toggles.
- Ack: sbuf_if.ack = (count != 2). It is decoded from the count flop only and has no path from ready_i or sbuf_if.rdy.
- Valid: valid_o = (count != 0).
- Output muxing:
  - When count != 0, outputs show entry[rptr].
  - When count == 0, insn_o = 32'h13 (NOP) and all other data outputs = 0.
- Latency: a push in cycle N makes valid_o high in cycle N+1 with that payload. There is no zero-cycle bypass.
- Count update: count_next = count + push - pop.
  - count 0: pop impossible.
  - count 1: simultaneous push+pop leaves count at 1; the new entry becomes head next cycle.
  - count 2: ack = 0, so no push; a pop returns count to 1 and ack to 1 the next cycle.
- Ordering: strict FIFO; no entry is lost or duplicated while ack = 0.
- Flush:
  - Next cycle: count = 0, wptr = rptr = 0, valid_o = 0, ack = 1.
  - A push or pop in the same cycle as flush is discarded; flush has priority.
  - Storage contents are not cleared.
- Reset (including assertion mid-transfer):
  - count, wptr, rptr = 0; valid_o = 0; sbuf_if.ack = 1.
  - Entries reset to insn 32'h13, all other fields 0.
  - insn_o = 32'h13; addr_o, idata*_o, fdata*_o = 0.
  - Any in-flight transfer is lost.
- Payload is sampled only on push; fields are unchanged while buffered regardless of upstream changes.

Optional Feature:
- Macro: RV0_SBUF_SINK_PERF_EN.
- With the macro defined:
  - Adds output stall_cnt_o[31:0]: counts cycles with sbuf_if.rdy && !sbuf_if.ack (upstream backpressured).
  - Adds output bubble_cnt_o[31:0]: counts cycles with ready_i && !valid_o (downstream starved).
  - Both counters reset to 0 on rst_i and wrap at 2^32 - 1 -> 0.
  - flush_i does not clear them.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- rv0_core_pkg holds RV0_INSN_NOP = 32'h13 and SBUF_DEPTH = 2 (count width derived from it).
- The payload width (32 + 3*XLEN + 2*FLEN) is a module localparam because it is parameter-dependent.
- Optional sub-module rv0_perf_cnt (32-bit enable/wrap counter), instantiated twice under RV0_SBUF_SINK_PERF_EN.
- No other sub-modules.

Test Plan:
- Single transfer: after reset, rdy=1 with addr=0x100, insn=0x00500093 for 1 cycle, ready_i=1 -> next cycle valid_o=1, insn_o=0x00500093, addr_o=0x100; following cycle valid_o=0, insn_o=0x13.
- Fill/backpressure: ready_i=0, push insns A=0x11, B=0x22 in back-to-back cycles -> ack=0 from the cycle after B; while rdy=1 with C=0x33 held, C is not taken. Release ready_i -> outputs A, B, C in order with no loss or duplication.
- Simultaneous push+pop at count=1: hold ready_i=1 and rdy=1 streaming insns 1..8 -> valid_o stays 1, ack stays 1, throughput 1/cycle, order 1..8.
- Flush with count=2 plus a concurrent push: next cycle valid_o=0, ack=1, insn_o=0x13; the next pushed entry 0x44 emerges first.
- Async reset mid-stream: assert rst_i between clock edges with count=2 -> valid_o=0 and ack=1 immediately, without waiting for a clock edge; after release, operation is normal.
- PERF_EN build: rdy=1 with buffer full for 5 cycles -> stall_cnt_o=5; ready_i=1 while empty for 3 cycles -> bubble_cnt_o=3; flush leaves both unchanged.
